// File: rtl/comp4_checker.sv
// Monitor for a 4-bit magnitude comparator: samples each {A,B,lt,gr,eq} vector, recomputes
// the expected one-hot code, keeps saturating pass/fail counts and captures the first failure.
module comp4_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             lt,
  input  logic             gr,
  input  logic             eq,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [2:0]       fail_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_nxt;

  logic             run_start;
  logic             sample;

  logic             stg_vld;
  logic [WIDTH-1:0] stg_a;
  logic [WIDTH-1:0] stg_b;
  logic [2:0]       stg_code;
  logic [2:0]       stg_exp;
  logic             stg_pass;

  // start only has effect from a resting state; it beats a simultaneous stop there
  assign run_start = start && ((state == IDLE) || (state == DONE));
  assign sample    = valid && (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop)  state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_vld  <= 1'b0;
      stg_a    <= '0;
      stg_b    <= '0;
      stg_code <= '0;
    end else begin
      stg_vld <= sample;
      if (sample) begin
        stg_a    <= A;
        stg_b    <= B;
        stg_code <= {lt, gr, eq};
      end
    end
  end

  // Expected code is strictly one-hot, so any non-one-hot response fails automatically
  assign stg_exp  = {(stg_a < stg_b), (stg_a > stg_b), (stg_a == stg_b)};
  assign stg_pass = (stg_code == stg_exp);

  always_ff @(posedge clk) begin
    if (reset || run_start) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err       <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_code <= '0;
    end else if (stg_vld) begin
      if (stg_pass) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
        err <= 1'b1;
        if (!err) begin
          fail_a    <= stg_a;
          fail_b    <= stg_b;
          fail_code <= stg_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_comp4_checker.sv
// Directed, table-driven bench for comp4_checker; a CNT_W=4 instance shares the stimulus
// so counter saturation can be observed.
module tb_comp4_checker;

  logic       clk = 1'b0;
  logic       reset, start, stop, valid;
  logic [3:0] A, B;
  logic       lt, gr, eq;

  logic       busy, done, err;
  logic [7:0] pass_cnt, fail_cnt;
  logic [3:0] fail_a, fail_b;
  logic [2:0] fail_code;

  logic       busy4, done4, err4;
  logic [3:0] pass_cnt4, fail_cnt4;
  logic [3:0] fail_a4, fail_b4;
  logic [2:0] fail_code4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  comp4_checker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .valid(valid),
    .A(A), .B(B), .lt(lt), .gr(gr), .eq(eq),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err(err), .fail_a(fail_a), .fail_b(fail_b), .fail_code(fail_code)
  );

  comp4_checker #(.WIDTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .valid(valid),
    .A(A), .B(B), .lt(lt), .gr(gr), .eq(eq),
    .busy(busy4), .done(done4), .pass_cnt(pass_cnt4), .fail_cnt(fail_cnt4),
    .err(err4), .fail_a(fail_a4), .fail_b(fail_b4), .fail_code(fail_code4)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] code;
    logic       pass;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [2:0] code);
    valid = 1'b1;
    A = a;
    B = b;
    {lt, gr, eq} = code;
    tick();
    valid = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 10) begin
      tick();
      k++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_pass"}, 32'(pass_cnt), 32'd0);
    check({name, "_fail"}, 32'(fail_cnt), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
    check({name, "_cap"}, 32'({fail_a, fail_b, fail_code}), 32'd0);
  endtask

  function automatic logic [2:0] exp_code(input logic [3:0] a, input logic [3:0] b);
    return {a < b, a > b, a == b};
  endfunction

  initial begin
    tbl[0]  = '{a: 4'd0,  b: 4'd0,  code: 3'b001, pass: 1'b1};
    tbl[1]  = '{a: 4'd15, b: 4'd15, code: 3'b001, pass: 1'b1};
    tbl[2]  = '{a: 4'd0,  b: 4'd15, code: 3'b100, pass: 1'b1};
    tbl[3]  = '{a: 4'd15, b: 4'd0,  code: 3'b010, pass: 1'b1};
    tbl[4]  = '{a: 4'd7,  b: 4'd8,  code: 3'b100, pass: 1'b1};
    tbl[5]  = '{a: 4'd8,  b: 4'd7,  code: 3'b100, pass: 1'b0};
    tbl[6]  = '{a: 4'd4,  b: 4'd4,  code: 3'b010, pass: 1'b0};
    tbl[7]  = '{a: 4'd1,  b: 4'd2,  code: 3'b001, pass: 1'b0};
    tbl[8]  = '{a: 4'd9,  b: 4'd9,  code: 3'b000, pass: 1'b0};
    tbl[9]  = '{a: 4'd3,  b: 4'd9,  code: 3'b011, pass: 1'b0};
    tbl[10] = '{a: 4'd3,  b: 4'd3,  code: 3'b101, pass: 1'b0};
    tbl[11] = '{a: 4'd12, b: 4'd2,  code: 3'b110, pass: 1'b0};
    tbl[12] = '{a: 4'd2,  b: 4'd12, code: 3'b111, pass: 1'b0};
    tbl[13] = '{a: 4'd6,  b: 4'd5,  code: 3'b010, pass: 1'b1};

    reset = 1'b1; start = 1'b0; stop = 1'b0; valid = 1'b0;
    A = '0; B = '0; lt = 1'b0; gr = 1'b0; eq = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_zero("reset");

    // stop and valid are ignored in IDLE
    stop = 1'b1;
    apply(4'd5, 4'd7, 3'b100);
    stop = 1'b0;
    tick();
    check_zero("idle_ignore");

    // Test 1: three correct vectors back to back
    do_start();
    check("t1_busy", 32'(busy), 32'd1);
    valid = 1'b1;
    A = 4'd5;  B = 4'd7;  {lt, gr, eq} = 3'b100; tick();
    A = 4'd10; B = 4'd7;  {lt, gr, eq} = 3'b010; tick();
    A = 4'd10; B = 4'd10; {lt, gr, eq} = 3'b001; tick();
    valid = 1'b0;
    do_stop();
    check("t1_drain_busy", 32'(busy), 32'd1);
    check("t1_drain_done", 32'(done), 32'd0);
    wait_done("t1");
    check("t1_busy_off", 32'(busy), 32'd0);
    check("t1_pass", 32'(pass_cnt), 32'd3);
    check("t1_fail", 32'(fail_cnt), 32'd0);
    check("t1_err", 32'(err), 32'd0);
    tick();
    check("t1_stable", 32'(pass_cnt), 32'd3);

    // start and stop together in DONE: start wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 32'd1);
    check("ss_pass_clr", 32'(pass_cnt), 32'd0);

    // Test 2: capture only the first failure; start in RUN is ignored
    apply(4'd5, 4'd7, 3'b010);
    start = 1'b1;
    apply(4'd3, 4'd3, 3'b000);
    start = 1'b0;
    do_stop();
    wait_done("t2");
    check("t2_fail", 32'(fail_cnt), 32'd2);
    check("t2_pass", 32'(pass_cnt), 32'd0);
    check("t2_err", 32'(err), 32'd1);
    check("t2_fa", 32'(fail_a), 32'd5);
    check("t2_fb", 32'(fail_b), 32'd7);
    check("t2_fc", 32'(fail_code), 32'b010);

    // Test 3: illegal code then restart clears everything
    do_start();
    apply(4'd10, 4'd7, 3'b111);
    do_stop();
    wait_done("t3");
    check("t3_fail", 32'(fail_cnt), 32'd1);
    check("t3_cap", 32'({fail_a, fail_b, fail_code}), 32'({4'd10, 4'd7, 3'b111}));
    do_start();
    check("t3_clr_busy", 32'(busy), 32'd1);
    check("t3_clr_cnt", 32'({pass_cnt, fail_cnt}), 32'd0);
    check("t3_clr_err", 32'(err), 32'd0);
    check("t3_clr_cap", 32'({fail_a, fail_b, fail_code}), 32'd0);

    // Test 4: 20 correct vectors saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      logic [3:0] a, b;
      a = 4'(i);
      b = 4'(i * 7 + 3);
      apply(a, b, exp_code(a, b));
    end
    do_stop();
    wait_done("t4");
    check("t4_pass8", 32'(pass_cnt), 32'd20);
    check("t4_pass4", 32'(pass_cnt4), 32'd15);
    check("t4_fail4", 32'(fail_cnt4), 32'd0);

    // Test 5: vector sampled together with stop is counted
    do_start();
    apply(4'd1, 4'd2, 3'b100);
    valid = 1'b1; stop = 1'b1;
    A = 4'd0; B = 4'd15; {lt, gr, eq} = 3'b100;
    tick();
    valid = 1'b0; stop = 1'b0;
    check("t5_done_e0", 32'(done), 32'd0);
    check("t5_pass_e0", 32'(pass_cnt), 32'd1);
    tick();
    check("t5_done_e1", 32'(done), 32'd1);
    check("t5_pass_e1", 32'(pass_cnt), 32'd2);

    // Test 6: reset mid-run with a staged vector
    do_start();
    apply(4'd5, 4'd7, 3'b010);
    valid = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; valid = 1'b0;
    check_zero("t6_rst");
    apply(4'd5, 4'd7, 3'b100);
    apply(4'd9, 4'd1, 3'b111);
    tick();
    check_zero("t6_nostart");

    // Table: one vector per run
    foreach (tbl[i]) begin
      do_start();
      apply(tbl[i].a, tbl[i].b, tbl[i].code);
      do_stop();
      wait_done($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_pass", i), 32'(pass_cnt), 32'(tbl[i].pass));
      check($sformatf("tbl%0d_fail", i), 32'(fail_cnt), 32'(!tbl[i].pass));
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(!tbl[i].pass));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
